operand_fwd_stage: RTL
======================

Name: operand_fwd_stage

Overview:
- Parametrised successor to the combinational ALU operand-B select. It resolves both EX operands (A and B) and store data, forwarding from the MEM and WB stages.
- Detects load-use hazards and holds the instruction for a configurable number of cycles.
- Registers the resolved operands into the ID/EX boundary under a valid/ready handshake.
- Sits between decode/register-file read and the ALU in the 5-stage RISC-V pipeline.

Parameters:
- DATAWIDTH, 32, operand/data width in bits.
- REGADDR, 5, register index width.
- LOAD_LAT, 1, load-use stall cycles; legal range 1..3.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts instruction this cycle.
- rs1, rs2  input  REGADDR  source register indices.
- rs1_used, rs2_used  input  1  source actually read by the instruction.
- rs1_data, rs2_data  input  DATAWIDTH  register file read data.
- imm  input  DATAWIDTH  immediate from immgen.
- pc  input  DATAWIDTH  instruction PC.
- asel  input  1  1 = op_a takes pc.
- bsel  input  1  1 = op_b takes imm.
- ex_rd  input  REGADDR  destination register of the instruction in EX.
- ex_memread  input  1  instruction in EX is a load.
- mem_rd  input  REGADDR  destination register in MEM.
- mem_regwen  input  1  MEM stage writes a register.
- mem_aludata  input  DATAWIDTH  ALU result in MEM.
- wb_rd  input  REGADDR  destination register in WB.
- wb_regwen  input  1  WB stage writes a register.
- wb_data  input  DATAWIDTH  writeback data.
- flush  input  1  branch/jump squash.
- out_valid  output  1  registered operands valid.
- out_ready  input  1  EX accepts operands.
- op_a, op_b, store_data  output  DATAWIDTH  registered operands.
- fwd_a_sel, fwd_b_sel  output  2  registered forward source: 00 regfile, 01 WB, 10 MEM.
- stall  output  1  load-use stall active (combinational).

Behaviour:
- Reset (async, rst=1): out_valid=0, op_a/op_b/store_data=0, fwd_*_sel=00, FSM=IDLE, stall counter=0.
- Forward select, per source (combinational):
  - MEM hit: mem_regwen && mem_rd!=0 && mem_rd==rsX. Source = mem_aludata, sel=10.
  - Otherwise WB hit: wb_regwen && wb_rd!=0 && wb_rd==rsX. Source = wb_data, sel=01.
  - Otherwise rsX_data, sel=00.
  - MEM has priority over WB. x0 is never forwarded.
- Operand rules: op_a = asel ? pc : fwdA. op_b = bsel ? imm : fwdB. store_data = fwdB regardless of bsel.
- Hazard: in_valid && ex_memread && ex_rd!=0 && ((rs1_used && rs1==ex_rd) || (rs2_used && rs2==ex_rd)). Evaluated only in IDLE.
- FSM:
  - IDLE, hazard: go to STALL, counter = LOAD_LAT-1, stall=1, in_ready=0.
  - STALL: stall=1, in_ready=0, ex_* ignored. Counter decrements each cycle. At counter==0, return to IDLE on the next edge.
  - With LOAD_LAT=1, stall is exactly one cycle.
- in_ready = (state==IDLE) && !hazard && (!out_valid || out_ready).
- Capture on in_valid && in_ready: output registers load the resolved values and out_valid=1 on the next edge.
- out_valid && out_ready && no capture: out_valid clears.
- out_valid && !out_ready: outputs hold stable and unchanged.
- Latency is 1 cycle from accept to out_valid with no hazard, and LOAD_LAT+1 cycles with a hazard.
- flush (synchronous effect):
  - Next edge: out_valid=0, FSM=IDLE, counter=0.
  - Flush overrides a simultaneous capture; the incoming instruction is dropped.
  - Data registers may keep stale values.
- Simultaneous MEM and WB hits on the same register: MEM wins.
- rs1==rs2: both operands use the same resolved source.
- rst asserted mid-STALL: immediate return to reset state. No residual stall after release.

Test Plan:
- No hazard: rs1=3, rs1_data=0x11, no stage hits, asel=0, bsel=1, imm=0x20, out_ready=1. Expect op_a=0x11, op_b=0x20, fwd_a_sel=00, out_valid one cycle after accept.
- Priority: rs2=5, mem_rd=5, mem_regwen=1, mem_aludata=0xAAAA, wb_rd=5, wb_regwen=1, wb_data=0xBBBB, bsel=0. Expect op_b=store_data=0xAAAA, fwd_b_sel=10. Repeat with rs2=0: expect rs2_data, sel=00.
- Load-use: LOAD_LAT=2, ex_memread=1, ex_rd=7, rs1=7, rs1_used=1. Expect stall=1 and in_ready=0 for exactly 2 cycles, then accept; with wb_rd=7, wb_data=0x55, op_a=0x55.
- Unused source: same as load-use but rs1_used=0. Expect no stall, accepted the same cycle.
- Backpressure: out_ready=0 after capture. op_a/op_b held for 3 cycles, in_ready=0. out_ready=1 releases; the next instruction is captured on the following edge.
- Flush and reset: flush during STALL gives out_valid=0, stall=0 next cycle. rst pulse mid-operation gives out_valid=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/operand_fwd_stage.sv
// ID/EX operand resolution: forwards MEM/WB results into both EX operands and
// store data, stalls on load-use hazards, and registers the result under valid/ready.
module operand_fwd_stage #(
  parameter int DATAWIDTH = 32,
  parameter int REGADDR   = 5,
  parameter int LOAD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REGADDR-1:0]   rs1,
  input  logic [REGADDR-1:0]   rs2,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [DATAWIDTH-1:0] rs1_data,
  input  logic [DATAWIDTH-1:0] rs2_data,
  input  logic [DATAWIDTH-1:0] imm,
  input  logic [DATAWIDTH-1:0] pc,
  input  logic                 asel,
  input  logic                 bsel,
  input  logic [REGADDR-1:0]   ex_rd,
  input  logic                 ex_memread,
  input  logic [REGADDR-1:0]   mem_rd,
  input  logic                 mem_regwen,
  input  logic [DATAWIDTH-1:0] mem_aludata,
  input  logic [REGADDR-1:0]   wb_rd,
  input  logic                 wb_regwen,
  input  logic [DATAWIDTH-1:0] wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] op_a,
  output logic [DATAWIDTH-1:0] op_b,
  output logic [DATAWIDTH-1:0] store_data,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 stall
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  state_t               state;
  logic [1:0]           cnt;
  logic [1:0]           sel_a, sel_b;
  logic [DATAWIDTH-1:0] fwd_a, fwd_b;
  logic                 hazard, capture;

  // MEM is the younger result, so it wins over WB; x0 is never forwarded.
  always_comb begin
    sel_a = 2'b00;
    fwd_a = rs1_data;
    if (mem_regwen && mem_rd != '0 && mem_rd == rs1) begin
      sel_a = 2'b10;
      fwd_a = mem_aludata;
    end else if (wb_regwen && wb_rd != '0 && wb_rd == rs1) begin
      sel_a = 2'b01;
      fwd_a = wb_data;
    end
  end

  always_comb begin
    sel_b = 2'b00;
    fwd_b = rs2_data;
    if (mem_regwen && mem_rd != '0 && mem_rd == rs2) begin
      sel_b = 2'b10;
      fwd_b = mem_aludata;
    end else if (wb_regwen && wb_rd != '0 && wb_rd == rs2) begin
      sel_b = 2'b01;
      fwd_b = wb_data;
    end
  end

  always_comb begin
    hazard   = (state == IDLE) && in_valid && ex_memread && (ex_rd != '0) &&
               ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
    stall    = hazard || (state == STALL);
    in_ready = (state == IDLE) && !hazard && (!out_valid || out_ready);
    capture  = in_valid && in_ready;
  end

  // The hazard-detect cycle is the first stall cycle; STALL covers the
  // remaining LOAD_LAT-1, so LOAD_LAT=1 never leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (hazard) begin
          cnt <= LAT_M1;
          if (LOAD_LAT > 1) state <= STALL;
        end
        STALL: if (cnt <= 2'd1) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 2'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      store_data <= '0;
      fwd_a_sel  <= 2'b00;
      fwd_b_sel  <= 2'b00;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      op_a       <= asel ? pc : fwd_a;
      op_b       <= bsel ? imm : fwd_b;
      store_data <= fwd_b;
      fwd_a_sel  <= sel_a;
      fwd_b_sel  <= sel_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
